// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into one little-endian word.
// The finished word appears combinationally with the 4th byte.
module byte_packer
  import loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       byte_in,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic [1:0]       byte_cnt
);
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    cnt_d      = cnt_q;
    data_d     = data_q;
    word_valid = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      data_d = '0;
    end else if (byte_valid) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (cnt_q == 2'(i)) data_d[8*i +: 8] = byte_in;
      end
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // data_d already carries the incoming top lane when word_valid fires.
  assign word     = data_d;
  assign byte_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: receives a length/payload/checksum frame, writes the words
// into instruction memory and releases the core only after verification.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0]      imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  // state   | meaning
  // IDLE    | waiting for start, core held
  // HDR0/1  | receiving word count low/high byte
  // PAYLOAD | receiving and writing program words
  // CSUM    | comparing received checksum
  // DONE    | image verified, core released
  // ERR     | length or checksum failure, core held
  localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

  state_e                 state_q, state_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [LEN_WIDTH-1:0]   n_q, n_d;
  logic [LEN_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [7:0]             csum_q, csum_d;
  logic                   imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
  logic [WIDTH-1:0]       imem_wdata_q, imem_wdata_d;
  logic                   core_rst_q, core_rst_d;

  logic                   accept;
  logic                   start_load;
  logic                   pack_valid;
  logic                   word_valid;
  logic [WIDTH-1:0]       word;
  logic [1:0]             byte_cnt;

  assign in_ready   = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state_q == S_PAYLOAD);

  byte_packer #(.WIDTH(WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_load),
    .byte_valid (pack_valid),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word),
    .byte_cnt   (byte_cnt)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    start_load   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          word_idx_d = '0;
          csum_d     = '0;
          start_load = 1'b1;
        end
      end
      S_HDR0: if (accept) begin
        len_lo_d = in_data;
        state_d  = S_HDR1;
      end
      S_HDR1: if (accept) begin
        n_d = {in_data, len_lo_q};
        if (n_d == '0)                 state_d = S_CSUM;
        else if ({1'b0, n_d} > DEPTH)  state_d = S_ERR;
        else                           state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (accept) begin
        csum_d = csum_q ^ in_data;
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
          imem_wdata_d = word;
          word_idx_d   = word_idx_q + LEN_WIDTH'(1);
          if (word_idx_q == n_q - LEN_WIDTH'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    core_rst_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      n_q          <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = in_ready;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
endmodule
